// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pkg
// Description : Shared constants and helpers for the byte-enabled TDP RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

    localparam int WM_NO_CHANGE   = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_WRITE_FIRST = 2;

    // merge() works on a fixed maximum width so one function serves every instance
    localparam int MERGE_MAX_W     = 256;
    localparam int MERGE_MAX_LANES = 32;

    typedef logic [MERGE_MAX_W-1:0]     merge_word_t;
    typedef logic [MERGE_MAX_LANES-1:0] merge_lanes_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic merge_word_t merge(input merge_word_t  old_word,
                                          input merge_word_t  din_word,
                                          input merge_lanes_t we,
                                          input int           byte_width);
        merge_word_t result;
        int          lane;
        result = old_word;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            lane = i / byte_width;
            if ((lane < MERGE_MAX_LANES) && we[5'(lane)]) begin
                result[8'(i)] = din_word[8'(i)];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdp_ram_port_out.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port_out
// Description : Per-port read pipeline: stage-1 register, optional output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_port_out #(
    parameter int W       = 32,
    parameter int OUT_REG = 1
) (
    input  logic         clka,
    input  logic         rstb,
    input  logic         rd_en,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    logic [W-1:0] r_s1_data;
    logic         r_s1_valid;

    // Data only moves on a read so the output holds between reads
    always_ff @(posedge clka) begin
        if (rstb) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= rd_en;
            if (rd_en) begin
                r_s1_data <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] r_s2_data;
            logic         r_s2_valid;

            always_ff @(posedge clka) begin
                if (rstb) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign dout       = r_s2_data;
            assign dout_valid = r_s2_valid;
        end else begin : g_no_out_reg
            assign dout       = r_s1_data;
            assign dout_valid = r_s1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tdp_ram_bytewe.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_bytewe
// Description : Single-clock true dual-port RAM with byte enables and collision handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_bytewe
    import tdp_ram_pkg::*;
#(
    parameter int    NUM_BYTES  = 4,
    parameter int    BYTE_WIDTH = 8,
    parameter int    RAM_DEPTH  = 1024,
    parameter string WRITE_MODE = "NO_CHANGE",
    parameter int    OUT_REG    = 1,
    localparam int   W          = NUM_BYTES * BYTE_WIDTH,
    localparam int   AW         = clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 enb,
    input  logic [NUM_BYTES-1:0] wea,
    input  logic [NUM_BYTES-1:0] web,
    input  logic [AW-1:0]        addra,
    input  logic [AW-1:0]        addrb,
    input  logic [W-1:0]         dina,
    input  logic [W-1:0]         dinb,
    output logic [W-1:0]         douta,
    output logic [W-1:0]         doutb,
    output logic                 douta_valid,
    output logic                 doutb_valid,
    output logic                 collision,
    output logic [15:0]          collision_cnt
);

    localparam int c_WM = (WRITE_MODE == "READ_FIRST")  ? WM_READ_FIRST  :
                          (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST : WM_NO_CHANGE;
    localparam logic          c_RD_ON_WRITE = (c_WM != WM_NO_CHANGE);
    localparam logic [AW:0]   c_DEPTH       = (AW+1)'(RAM_DEPTH);

    logic [W-1:0] r_mem [RAM_DEPTH] = '{default: '0};

    logic         w_a_inr, w_b_inr, w_same_addr;
    logic         w_a_wr, w_b_wr, w_a_rd, w_b_rd, w_coll;
    logic [W-1:0] w_a_old, w_b_old, w_final, w_a_view, w_b_view;
    logic [W-1:0] w_a_rdata, w_b_rdata;
    logic         r_coll;
    logic [15:0]  r_cnt;

    assign w_a_inr     = ({1'b0, addra} < c_DEPTH);
    assign w_b_inr     = ({1'b0, addrb} < c_DEPTH);
    assign w_a_old     = w_a_inr ? r_mem[addra] : '0;
    assign w_b_old     = w_b_inr ? r_mem[addrb] : '0;
    assign w_same_addr = ena & enb & w_a_inr & w_b_inr & (addra == addrb);

    assign w_a_wr = ~rstb & ena & w_a_inr & (|wea);
    assign w_b_wr = ~rstb & enb & w_b_inr & (|web);
    assign w_coll = ~rstb & w_same_addr & (|(wea | web));
    assign w_a_rd = ena & ((wea == '0) | c_RD_ON_WRITE);
    assign w_b_rd = enb & ((web == '0) | c_RD_ON_WRITE);

    // Word as it will look after both ports write the same address, A on top
    assign w_final  = W'(merge(merge(merge_word_t'(w_a_old), merge_word_t'(dinb),
                                     merge_lanes_t'(web), BYTE_WIDTH),
                               merge_word_t'(dina), merge_lanes_t'(wea), BYTE_WIDTH));
    assign w_a_view = (w_same_addr & w_b_wr) ? w_final :
                      W'(merge(merge_word_t'(w_a_old), merge_word_t'(dina),
                               merge_lanes_t'(wea), BYTE_WIDTH));
    assign w_b_view = (w_same_addr & w_a_wr) ? w_final :
                      W'(merge(merge_word_t'(w_b_old), merge_word_t'(dinb),
                               merge_lanes_t'(web), BYTE_WIDTH));

    // A pure reader always sees the pre-write word, even under collision
    always_comb begin
        w_a_rdata = w_a_old;
        w_b_rdata = w_b_old;
        if (w_a_inr && (wea != '0) && (c_WM == WM_WRITE_FIRST)) begin
            w_a_rdata = w_a_view;
        end
        if (w_b_inr && (web != '0) && (c_WM == WM_WRITE_FIRST)) begin
            w_b_rdata = w_b_view;
        end
    end

    // Port A lanes are written last so they win on overlapping lanes
    always_ff @(posedge clka) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_b_wr && web[i]) begin
                r_mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (w_a_wr && wea[i]) begin
                r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            r_coll <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign collision     = r_coll;
    assign collision_cnt = r_cnt;

    tdp_ram_port_out #(.W(W), .OUT_REG(OUT_REG)) u_port_a (
        .clka       (clka),
        .rstb       (rstb),
        .rd_en      (w_a_rd),
        .rd_data    (w_a_rdata),
        .dout       (douta),
        .dout_valid (douta_valid)
    );

    tdp_ram_port_out #(.W(W), .OUT_REG(OUT_REG)) u_port_b (
        .clka       (clka),
        .rstb       (rstb),
        .rd_en      (w_b_rd),
        .rd_data    (w_b_rdata),
        .dout       (doutb),
        .dout_valid (doutb_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_bytewe.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdp_ram_bytewe
// Description : Scoreboard bench for tdp_ram_bytewe across write modes and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_bytewe;

    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic        ena = 1'b0, enb = 1'b0;
    logic [3:0]  wea = '0, web = '0;
    logic [9:0]  addra = '0, addrb = '0;
    logic [31:0] dina = '0, dinb = '0;

    logic [31:0] nc_douta, nc_doutb, rf_douta, rf_doutb, wf_douta, wf_doutb;
    logic        nc_va, nc_vb, rf_va, rf_vb, wf_va, wf_vb;
    logic        nc_coll, rf_coll, wf_coll;
    logic [15:0] nc_cnt, rf_cnt, wf_cnt;

    always #5 clka = ~clka;

    tdp_ram_bytewe #(.WRITE_MODE("NO_CHANGE"), .OUT_REG(1), .RAM_DEPTH(1024)) dut_nc (
        .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(nc_douta), .doutb(nc_doutb), .douta_valid(nc_va), .doutb_valid(nc_vb),
        .collision(nc_coll), .collision_cnt(nc_cnt));

    tdp_ram_bytewe #(.WRITE_MODE("READ_FIRST"), .OUT_REG(1), .RAM_DEPTH(1024)) dut_rf (
        .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(rf_douta), .doutb(rf_doutb), .douta_valid(rf_va), .doutb_valid(rf_vb),
        .collision(rf_coll), .collision_cnt(rf_cnt));

    tdp_ram_bytewe #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(0), .RAM_DEPTH(1000)) dut_wf (
        .clka(clka), .rstb(rstb), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(wf_douta), .doutb(wf_doutb), .douta_valid(wf_va), .doutb_valid(wf_vb),
        .collision(wf_coll), .collision_cnt(wf_cnt));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [1024];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a = '0, last_b = '0, mon_a, mon_b;
    logic [15:0] exp_cnt = '0;

    // Scoreboard for the NO_CHANGE / OUT_REG=1 instance
    always @(negedge clka) begin
        if (nc_va === 1'b1) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL sb_a: douta_valid with no read pending, douta=%h", nc_douta);
            end else begin
                mon_a  = qa.pop_front();
                last_a = mon_a;
                if (nc_douta !== mon_a) begin
                    bad++;
                    $display("FAIL sb_a: douta=%h expected %h", nc_douta, mon_a);
                end
            end
        end
        if (nc_vb === 1'b1) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL sb_b: doutb_valid with no read pending, doutb=%h", nc_doutb);
            end else begin
                mon_b  = qb.pop_front();
                last_b = mon_b;
                if (nc_doutb !== mon_b) begin
                    bad++;
                    $display("FAIL sb_b: doutb=%h expected %h", nc_doutb, mon_b);
                end
            end
        end
    end

    task automatic step(input logic r, input logic ea, input logic [3:0] wa, input logic [9:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [9:0] ab, input logic [31:0] db);
        logic c;
        rstb = r; ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        if (!r && ea && (wa == 4'h0)) qa.push_back(model[aa]);
        if (!r && eb && (wb == 4'h0)) qb.push_back(model[ab]);
        c = !r && ea && eb && (aa == ab) && ((wa | wb) != 4'h0);
        if (!r) begin
            for (int i = 0; i < 4; i++) if (eb && wb[i]) model[ab][i*8 +: 8] = db[i*8 +: 8];
            for (int i = 0; i < 4; i++) if (ea && wa[i]) model[aa][i*8 +: 8] = da[i*8 +: 8];
        end
        if (c && (exp_cnt != 16'hFFFF)) exp_cnt++;
        @(posedge clka);
        #1;
        if (r) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0; exp_cnt = '0;
        end
        total++;
        if (nc_coll !== c) begin
            bad++;
            $display("FAIL collision_pulse: got %b expected %b", nc_coll, c);
        end
        total++;
        if (nc_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL collision_cnt: got %h expected %h", nc_cnt, exp_cnt);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        total++;
        if ({nc_douta, nc_doutb, nc_va, nc_vb, nc_coll, nc_cnt} !== 83'h0) begin
            bad++;
            $display("FAIL reset_nc: a=%h b=%h va=%b vb=%b coll=%b cnt=%h",
                     nc_douta, nc_doutb, nc_va, nc_vb, nc_coll, nc_cnt);
        end
        total++;
        if ({wf_douta, wf_doutb, wf_va, wf_vb} !== 66'h0) begin
            bad++;
            $display("FAIL reset_wf: a=%h b=%h va=%b vb=%b", wf_douta, wf_doutb, wf_va, wf_vb);
        end
        step(1'b0, 1'b1, 4'h0, 10'd100, 32'h0, 1'b1, 4'h0, 10'd100, 32'h0);
        idle();
        idle();
    endtask

    task automatic test_basic();
        step(1'b0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 4'h0, 10'd0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0);
        total++;
        if (nc_vb !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: doutb_valid=%b expected 0", nc_vb);
        end
        total++;
        if (wf_vb !== 1'b1 || wf_doutb !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_lat1: valid=%b doutb=%h expected 1/deadbeef", wf_vb, wf_doutb);
        end
        idle();
        total++;
        if (nc_vb !== 1'b1 || nc_doutb !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_lat2: valid=%b doutb=%h expected 1/deadbeef", nc_vb, nc_doutb);
        end
        idle();
        total++;
        if (nc_vb !== 1'b0 || nc_doutb !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_hold: valid=%b doutb=%h expected 0/deadbeef", nc_vb, nc_doutb);
        end
    endtask

    task automatic test_byte_lanes();
        step(1'b0, 1'b1, 4'hF, 10'd7, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'h0);
        step(1'b0, 1'b1, 4'h5, 10'd7, 32'hAABBCCDD, 1'b0, 4'h0, 10'd0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd7, 32'h0);
        idle();
        total++;
        if (nc_vb !== 1'b1 || nc_doutb !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_lanes: valid=%b doutb=%h expected 1/11bb33dd", nc_vb, nc_doutb);
        end
        idle();
    endtask

    task automatic test_write_modes();
        step(1'b0, 1'b1, 4'hF, 10'd3, 32'h1, 1'b0, 4'h0, 10'd0, 32'h0);
        idle();
        idle();
        step(1'b0, 1'b1, 4'hF, 10'd3, 32'h2, 1'b0, 4'h0, 10'd0, 32'h0);
        total++;
        if (wf_va !== 1'b1 || wf_douta !== 32'h2) begin
            bad++;
            $display("FAIL wm_write_first: valid=%b douta=%h expected 1/00000002", wf_va, wf_douta);
        end
        idle();
        total++;
        if (rf_va !== 1'b1 || rf_douta !== 32'h1) begin
            bad++;
            $display("FAIL wm_read_first: valid=%b douta=%h expected 1/00000001", rf_va, rf_douta);
        end
        total++;
        if (nc_va !== 1'b0 || nc_douta !== last_a) begin
            bad++;
            $display("FAIL wm_no_change: valid=%b douta=%h expected 0/%h", nc_va, nc_douta, last_a);
        end
        idle();
    endtask

    task automatic test_collision();
        step(1'b0, 1'b1, 4'hF, 10'd9, 32'hAAAAAAAA, 1'b1, 4'hF, 10'd9, 32'hBBBBBBBB);
        total++;
        if (nc_coll !== 1'b1 || nc_cnt !== 16'd1) begin
            bad++;
            $display("FAIL coll_first: coll=%b cnt=%h expected 1/0001", nc_coll, nc_cnt);
        end
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
        idle();
        total++;
        if (nc_doutb !== 32'hAAAAAAAA) begin
            bad++;
            $display("FAIL coll_a_wins: doutb=%h expected aaaaaaaa", nc_doutb);
        end
        step(1'b0, 1'b1, 4'h3, 10'd9, 32'hAAAAAAAA, 1'b1, 4'hC, 10'd9, 32'hBBBBBBBB);
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
        idle();
        total++;
        if (nc_doutb !== 32'hBBBBAAAA || nc_cnt !== 16'd2) begin
            bad++;
            $display("FAIL coll_split: doutb=%h cnt=%h expected bbbbaaaa/0002", nc_doutb, nc_cnt);
        end
        step(1'b0, 1'b1, 4'h0, 10'd9, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
        total++;
        if (nc_coll !== 1'b0) begin
            bad++;
            $display("FAIL coll_both_read: coll=%b expected 0", nc_coll);
        end
        idle();
        idle();
    endtask

    task automatic test_reader_writer();
        step(1'b0, 1'b1, 4'hF, 10'd2, 32'h5, 1'b0, 4'h0, 10'd0, 32'h0);
        step(1'b0, 1'b1, 4'hF, 10'd2, 32'h6, 1'b1, 4'h0, 10'd2, 32'h0);
        total++;
        if (wf_doutb !== 32'h5 || wf_douta !== 32'h6) begin
            bad++;
            $display("FAIL rw_wf: doutb=%h douta=%h expected 00000005/00000006", wf_doutb, wf_douta);
        end
        step(1'b0, 1'b1, 4'h0, 10'd2, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        total++;
        if (nc_vb !== 1'b1 || nc_doutb !== 32'h5) begin
            bad++;
            $display("FAIL rw_reader_old: valid=%b doutb=%h expected 1/00000005", nc_vb, nc_doutb);
        end
        idle();
        total++;
        if (nc_va !== 1'b1 || nc_douta !== 32'h6) begin
            bad++;
            $display("FAIL rw_next_read: valid=%b douta=%h expected 1/00000006", nc_va, nc_douta);
        end
    endtask

    task automatic test_reset_midpipe();
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd2, 32'h0);
        step(1'b1, 1'b1, 4'hF, 10'd2, 32'hFFFFFFFF, 1'b0, 4'h0, 10'd0, 32'h0);
        total++;
        if (nc_vb !== 1'b0 || nc_doutb !== 32'h0 || nc_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b doutb=%h cnt=%h expected 0/0/0", nc_vb, nc_doutb, nc_cnt);
        end
        idle();
        total++;
        if (nc_vb !== 1'b0) begin
            bad++;
            $display("FAIL reset_flush: doutb_valid=%b expected 0", nc_vb);
        end
        step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd2, 32'h0);
        idle();
        total++;
        if (nc_vb !== 1'b1 || nc_doutb !== 32'h6) begin
            bad++;
            $display("FAIL reset_mem_kept: valid=%b doutb=%h expected 1/00000006", nc_vb, nc_doutb);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        step(1'b0, 1'b1, 4'hF, 10'd1010, 32'h12345678, 1'b1, 4'hF, 10'd1010, 32'h87654321);
        total++;
        if (wf_coll !== 1'b0 || wf_douta !== 32'h0) begin
            bad++;
            $display("FAIL oor_write: coll=%b douta=%h expected 0/0", wf_coll, wf_douta);
        end
        step(1'b0, 1'b1, 4'h0, 10'd1010, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        total++;
        if (wf_va !== 1'b1 || wf_douta !== 32'h0) begin
            bad++;
            $display("FAIL oor_read: valid=%b douta=%h expected 1/0", wf_va, wf_douta);
        end
        idle();
        idle();
    endtask

    task automatic test_counter_saturation();
        step(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
        for (int n = 0; n < 65536; n++) begin
            step(1'b0, 1'b1, 4'h1, 10'd9, n, 1'b1, 4'h2, 10'd9, ~n);
        end
        total++;
        if (nc_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_saturate: cnt=%h expected ffff", nc_cnt);
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 4'hF, 10'd9, 32'h0, 1'b1, 4'hF, 10'd9, 32'h0);
        end
        total++;
        if (nc_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_hold: cnt=%h expected ffff", nc_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_write_modes();
        test_collision();
        test_reader_writer();
        test_reset_midpipe();
        test_out_of_range();
        test_counter_saturation();
        for (int i = 0; i < 4; i++) idle();
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending reads a=%0d b=%0d expected 0/0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
